// File: rtl/gpio_switch_debounce_pkg.sv
// Shared constants and width helpers for the switch debounce slice.
package gpio_defs;

    // Default number of board switches feeding gpio_top.
    localparam int NUM_SW_DEF = 16;

    // Default number of consecutive differing samples needed to accept a level.
    localparam int DB_TICKS_DEF = 20;

    // Per-bit debounce counter width; must hold values up to DB_TICKS.
    function automatic int db_cnt_w(input int db_ticks);
        return $clog2(db_ticks + 1);
    endfunction

    // Prescaler counter width; a divide-by-one prescaler still needs one bit.
    function automatic int tick_cnt_w(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

    localparam int DB_CNT_W_DEF = db_cnt_w(DB_TICKS_DEF);

endpackage

// File: rtl/gpio_db_cell.sv
// Single-bit debouncer: accepts a new level after DB_TICKS consecutive
// sample ticks on which the synchronised input differs from the held level.
module gpio_db_cell
    import gpio_defs::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sync,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int                   CNT_W    = db_cnt_w(DB_TICKS);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DB_TICKS - 1);

    logic [CNT_W-1:0] db_cnt_r;
    logic [CNT_W-1:0] db_cnt_nxt_s;
    logic             db_r;
    logic             db_nxt_s;
    logic             rise_r;
    logic             rise_nxt_s;
    logic             fall_r;
    logic             fall_nxt_s;

    // Next-state: any agreeing cycle clears progress; differing ticks count up to acceptance.
    always_comb begin
        db_cnt_nxt_s = db_cnt_r;
        db_nxt_s     = db_r;
        rise_nxt_s   = 1'b0;
        fall_nxt_s   = 1'b0;
        if (sync == db_r) begin
            db_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (tick) begin
            if (db_cnt_r == CNT_LAST) begin
                db_nxt_s     = sync;
                db_cnt_nxt_s = {CNT_W{1'b0}};
                rise_nxt_s   = sync;
                fall_nxt_s   = ~sync;
            end else begin
                db_cnt_nxt_s = db_cnt_r + 1'b1;
            end
        end else begin
            db_cnt_nxt_s = db_cnt_r;
        end
    end

    // State and registered event pulses; reset discards any debounce progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_r <= {CNT_W{1'b0}};
            db_r     <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            db_cnt_r <= db_cnt_nxt_s;
            db_r     <= db_nxt_s;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
        end
    end

    assign db   = db_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/gpio_switch_debounce.sv
// Raw switch conditioner: per-bit synchroniser, shared sample-tick prescaler,
// per-bit debounce cells and an aggregate change strobe for gpio_top.
module gpio_switch_debounce
    import gpio_defs::*;
#(
    parameter int NUM_SW      = NUM_SW_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 50000,
    parameter int DB_TICKS    = DB_TICKS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_raw_i,
    output logic [NUM_SW-1:0] sw_db_o,
    output logic [NUM_SW-1:0] sw_rise_o,
    output logic [NUM_SW-1:0] sw_fall_o,
    output logic              sw_chg_o,
    output logic              tick_o
);

    localparam int                TICK_W    = tick_cnt_w(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [NUM_SW-1:0] sync_r [SYNC_STAGES];
    logic [NUM_SW-1:0] sw_sync_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [TICK_W-1:0] tick_cnt_nxt_s;
    logic              tick_s;

    // Multi-flop synchroniser; the raw pins are used nowhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {NUM_SW{1'b0}};
            end
        end else begin
            sync_r[0] <= sw_raw_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign sw_sync_s = sync_r[SYNC_STAGES-1];

    // Prescaler next count: wrap at TICK_DIV-1.
    always_comb begin
        tick_cnt_nxt_s = tick_cnt_r;
        if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_nxt_s = {TICK_W{1'b0}};
        end else begin
            tick_cnt_nxt_s = tick_cnt_r + 1'b1;
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_nxt_s;
        end
    end

    // Strobe decodes the registered count; masked during reset so a
    // divide-by-one prescaler still reads 0 while rst is held.
    assign tick_s = (tick_cnt_r == TICK_LAST) & ~rst;
    assign tick_o = tick_s;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
        gpio_db_cell #(
            .DB_TICKS (DB_TICKS)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .tick (tick_s),
            .sync (sw_sync_s[i]),
            .db   (sw_db_o[i]),
            .rise (sw_rise_o[i]),
            .fall (sw_fall_o[i])
        );
    end

    assign sw_chg_o = (|sw_rise_o) | (|sw_fall_o);

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Directed bench for gpio_switch_debounce with a cycle-level behavioural
// model (raw history queue, tick from cycle index, run-length of differing
// samples) compared against the DUT on every cycle, plus literal pins.
module tb_gpio_switch_debounce;

    localparam int NSW  = 4;
    localparam int SYNC = 2;
    localparam int TDIV = 4;
    localparam int DBT  = 3;

    logic           clk;
    logic           rst;
    logic [NSW-1:0] sw_raw_i;
    logic [NSW-1:0] sw_db_o;
    logic [NSW-1:0] sw_rise_o;
    logic [NSW-1:0] sw_fall_o;
    logic           sw_chg_o;
    logic           tick_o;

    gpio_switch_debounce #(
        .NUM_SW      (NSW),
        .SYNC_STAGES (SYNC),
        .TICK_DIV    (TDIV),
        .DB_TICKS    (DBT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw_i  (sw_raw_i),
        .sw_db_o   (sw_db_o),
        .sw_rise_o (sw_rise_o),
        .sw_fall_o (sw_fall_o),
        .sw_chg_o  (sw_chg_o),
        .tick_o    (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Model state: k = index of the current cycle since reset release.
    int             k = 0;
    logic [NSW-1:0] raw_q [$];
    logic [NSW-1:0] m_db   = '0;
    logic [NSW-1:0] m_rise = '0;
    logic [NSW-1:0] m_fall = '0;
    int             runs [NSW];

    task automatic chk(input string name, input logic [NSW-1:0] act, input logic [NSW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d t=%0t: got %b expected %b", name, k, $time, act, exp);
        end
    endtask

    // Model: sync is the raw value SYNC edges old; a bit flips after DBT
    // sampled ticks in a row disagree with it, any agreeing cycle clears the run.
    always @(posedge clk) begin
        logic [NSW-1:0] sync_now;
        bit             tick_now;
        if (rst) begin
            raw_q.delete();
            for (int s = 0; s < SYNC; s++) raw_q.push_back('0);
            m_db = '0; m_rise = '0; m_fall = '0;
            for (int b = 0; b < NSW; b++) runs[b] = 0;
            k = 0;
        end else begin
            sync_now = raw_q[0];
            tick_now = ((k % TDIV) == TDIV - 1);
            m_rise = '0; m_fall = '0;
            for (int b = 0; b < NSW; b++) begin
                if (sync_now[b] == m_db[b]) runs[b] = 0;
                else if (tick_now) begin
                    runs[b] = runs[b] + 1;
                    if (runs[b] == DBT) begin
                        m_db[b] = sync_now[b];
                        if (sync_now[b]) m_rise[b] = 1'b1;
                        else m_fall[b] = 1'b1;
                        runs[b] = 0;
                    end
                end
            end
            void'(raw_q.pop_front());
            raw_q.push_back(sw_raw_i);
            k = k + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("db",   sw_db_o,   m_db);
            chk("rise", sw_rise_o, m_rise);
            chk("fall", sw_fall_o, m_fall);
            chk("chg",  {3'b000, sw_chg_o}, {3'b000, ((|m_rise) | (|m_fall))});
            chk("tick", {3'b000, tick_o},   {3'b000, (!rst && (k % TDIV) == TDIV - 1)});
        end
    end

    // Pulse tallies for the once-only literal checks.
    int rise1_cnt = 0;
    int fall0_cnt = 0;
    int chg_cnt   = 0;
    always @(negedge clk) begin
        if (armed && !rst) begin
            if (sw_rise_o[1]) rise1_cnt++;
            if (sw_fall_o[0]) fall0_cnt++;
            if (sw_chg_o)     chg_cnt++;
        end
    end

    // Advance to the negedge of cycle c, bounded.
    task automatic wait_k(input int c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (k != c && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (k != c) begin
            errors++;
            checks++;
            $display("FAIL wait_k timeout: at k=%0d wanted k=%0d", k, c);
        end
    endtask

    initial begin
        rst = 1'b1;
        sw_raw_i = 4'hF;
        @(posedge clk);
        #1 armed = 1'b1;
        // 1: reset with all raw switches high
        repeat (3) @(negedge clk);
        chk("rst_db",   sw_db_o,   4'b0000);
        chk("rst_rise", sw_rise_o, 4'b0000);
        chk("rst_tick", {3'b000, tick_o}, 4'b0000);
        // release: current cycle becomes cycle 0, bit0 pressed
        rst = 1'b0;
        sw_raw_i = 4'b0001;
        wait_k(2);
        chk("tick_c2", {3'b000, tick_o}, 4'b0000);
        wait_k(3);
        chk("tick_c3", {3'b000, tick_o}, 4'b0001);
        wait_k(7);
        chk("tick_c7", {3'b000, tick_o}, 4'b0001);
        // 2: clean press accepted at cycle 12
        wait_k(11);
        chk("press_c11_db", sw_db_o, 4'b0000);
        wait_k(12);
        chk("press_c12_db",   sw_db_o,   4'b0001);
        chk("press_c12_rise", sw_rise_o, 4'b0001);
        chk("press_c12_chg",  {3'b000, sw_chg_o}, 4'b0001);
        wait_k(13);
        chk("press_c13_rise", sw_rise_o, 4'b0000);
        // 3: bounce bit1 every 5 cycles for 40 cycles
        wait_k(20);
        for (int s = 0; s < 8; s++) begin
            sw_raw_i[1] = (s % 2 == 0);
            wait_k(25 + 5 * s);
        end
        chk("bounce_db", sw_db_o, 4'b0001);
        chk("bounce_rise1", 4'(rise1_cnt), 4'd0);
        sw_raw_i[1] = 1'b1;
        wait_k(72);
        chk("hold_c72_db",   sw_db_o,   4'b0011);
        chk("hold_c72_rise", sw_rise_o, 4'b0010);
        // 4: release bit0
        wait_k(80);
        sw_raw_i[0] = 1'b0;
        wait_k(92);
        chk("rel_c92_fall", sw_fall_o, 4'b0001);
        chk("rel_c92_db",   sw_db_o,   4'b0010);
        // 5: simultaneous bits 2 and 3
        wait_k(100);
        chk("rel_fall0", 4'(fall0_cnt), 4'd1);
        chk("hold_rise1", 4'(rise1_cnt), 4'd1);
        chg_cnt = 0;
        sw_raw_i = 4'b1110;
        wait_k(112);
        chk("sim_c112_rise", sw_rise_o, 4'b1100);
        chk("sim_c112_db",   sw_db_o,   4'b1110);
        wait_k(119);
        chk("sim_chg_cycles", 4'(chg_cnt), 4'd1);
        // 6: drop bit2, reset when its count sits at 2 (ticks 123, 127)
        wait_k(120);
        sw_raw_i = 4'b1010;
        wait_k(129);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_db",   sw_db_o,   4'b0000);
        chk("mid_rst_fall", sw_fall_o, 4'b0000);
        rst = 1'b0;
        wait_k(11);
        chk("post_c11_rise", sw_rise_o, 4'b0000);
        wait_k(12);
        chk("post_c12_rise", sw_rise_o, 4'b1010);
        chk("post_c12_db",   sw_db_o,   4'b1010);
        wait_k(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
